// File: rtl/clk_div_ctrl.sv
// Run-control front end for the clock divider: programmable ratio, start/stop/pause/step FSM,
// registered one-cycle tick enable and near-50 % divided square wave.
module clk_div_ctrl #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_out,
    output logic             running
);
    typedef enum logic [1:0] {StIdle, StRun, StPause, StStep} state_e;

    localparam logic [CNT_W-1:0] MinDiv   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ResetDiv = CNT_W'(DEFAULT_DIV);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic             active_q, active_d;
    logic             cfg_xfer, wrap;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        active_q  = (state_q == StRun) || (state_q == StStep);
        cfg_xfer  = cfg_valid && !active_q;
        wrap      = (cnt_q == div_q - CNT_W'(1));

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StPause;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = StRun;
                end else if (step) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                if (stop) begin
                    state_d = StPause;
                end else if (wrap) begin
                    state_d = StPause;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A ratio accepted alongside a command applies to the state being entered.
        if (cfg_xfer) begin
            div_d = (cfg_div < MinDiv) ? MinDiv : cfg_div;
            cnt_d = '0;
        end

        // Outputs are registered from the next-cycle values so they line up with cnt.
        active_d = (state_d == StRun) || (state_d == StStep);
        tick_d   = active_d && (cnt_d == div_d - CNT_W'(1));
        if (active_d) begin
            clk_out_d = (cnt_d >= (div_d >> 1));
        end else if (state_d == StPause) begin
            clk_out_d = clk_out_q;
        end else begin
            clk_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= ResetDiv;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick      = tick_q;
    assign clk_out   = clk_out_q;
    assign running   = active_q;
    assign cfg_ready = !active_q;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-control front end for the 50 MHz clock-divider datapath. It holds a programmable divide ratio and runs a start/stop/pause/single-step state machine around the divide counter. It emits a one-cycle `tick` clock-enable and a near-50 % `clk_out` square wave. Downstream timekeeping and display logic use `tick` as an enable, and the system controller reconfigures the ratio through a valid/ready handshake.

## Interface
- `CNT_W`, 26: width of the divide counter and of `cfg_div`.
- `DEFAULT_DIV`, 50_000_000: ratio loaded at reset (1 Hz from 50 MHz). Benches override it with a small value.

- `clk_50MHz`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled command: run or resume.
- `stop`  in  1  level-sampled command: pause, or return to idle.
- `step`  in  1  level-sampled command: run one period from PAUSE.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_div`  in  CNT_W  offered ratio.
- `cfg_ready`  out  1  ratio can be accepted.
- `tick`  out  1  one-cycle enable, once per period.
- `clk_out`  out  1  divided square wave.
- `running`  out  1  counter is advancing (RUN or STEP).

## Operation
- **Registers**
  - `state` ∈ {IDLE, RUN, PAUSE, STEP}.
  - `cnt` (CNT_W bits).
  - `div_active` (CNT_W bits).
- **Reset values** (`reset` low, asynchronous)
  - `state` = IDLE, `cnt` = 0, `div_active` = DEFAULT_DIV.
  - `tick` = 0, `clk_out` = 0, `running` = 0, `cfg_ready` = 1.
- **Command priority** when several commands are high in one cycle: stop > start > step. Commands that have no transition in the current state are ignored.
- **Transitions**
  - IDLE + start → RUN, `cnt` = 0.
  - RUN + stop → PAUSE. `cnt` and `clk_out` are frozen.
  - PAUSE + start → RUN, resuming from the held `cnt`.
  - PAUSE + step → STEP.
  - PAUSE + stop → IDLE. `cnt` = 0, `clk_out` = 0.
  - STEP + stop → PAUSE, aborting the step.
  - STEP: when `cnt` wraps (tick cycle), the next state is PAUSE with `cnt` = 0.
- **Counting** (RUN/STEP only)
  - `cnt` increments by 1 per cycle.
  - At `cnt == div_active-1` it wraps to 0 on the next edge.
- **tick**
  - Registered output.
  - High exactly in the cycles where `cnt == div_active-1` and state is RUN or STEP.
  - Never high in IDLE or PAUSE.
- **clk_out**
  - Registered output.
  - In RUN/STEP, equals (`cnt >= div_active>>1`) for the current `cnt`.
  - In PAUSE it holds its value. In IDLE it is 0.
  - Odd ratios give a low phase of floor(div/2) cycles.
- **running** = 1 exactly when state is RUN or STEP, and is registered with the state.
- **Configuration handshake**
  - `cfg_ready` = 1 in IDLE and PAUSE, 0 in RUN and STEP.
  - A transfer occurs on an edge where `cfg_valid && cfg_ready`.
  - On transfer, `div_active` = max(`cfg_div`, 2) and `cnt` = 0, both visible next cycle. `cfg_div` values 0 and 1 are clamped to 2.
  - If a transfer and a command occur in the same cycle, both take effect: the new ratio and `cnt` = 0 apply to the entered state. Example: PAUSE + start + cfg gives RUN starting from `cnt` 0 with the new ratio.
- **Unaccepted configuration:** `cfg_valid` while `cfg_ready` = 0 is ignored. The offer is not queued, and the requester keeps it asserted until `cfg_ready` is high.

## Timing
- **Command latency:** a command sampled at edge k changes `state`, `running` and `cfg_ready` after edge k.
- **First tick after start:** with `start` sampled at edge k, RUN begins in cycle k+1 with `cnt` = 0. The first `tick` is in cycle k+div, and then every div cycles.
- **Tick spacing:** exactly `div_active` cycles in steady RUN.
- **Resume from `cnt` = c:** the next `tick` comes `div_active-1-c` cycles after the first RUN cycle.
- **Mid-operation reset:** outputs go to their reset values immediately, without waiting for a clock edge. Release is synchronous in effect; the first edge after release sees IDLE.

## Test plan
- **Reset:** `DEFAULT_DIV`=10; hold `reset` low 3 cycles → `tick`/`clk_out`/`running` = 0, `cfg_ready` = 1. A `start` during reset has no effect.
- **Run:** `DEFAULT_DIV`=10; pulse `start` → `running` = 1 next cycle. `tick` appears on the 10th RUN cycle, then every 10 cycles. `clk_out` is 5 low / 5 high. Check over 5 periods.
- **Configure and clamp:** in IDLE, load `cfg_div`=3, then start → tick period 3, `clk_out` 1 low / 2 high. Load `cfg_div`=1 → period 2. Assert `cfg_valid` in RUN → `cfg_ready` = 0 and the ratio is unchanged.
- **Pause and resume:** div 10; stop at `cnt`=4 → PAUSE, no ticks for 20 cycles, `clk_out` held. Start → `tick` on the 6th RUN cycle after resume. Stop twice → IDLE with `clk_out` = 0.
- **Single step and priority:** from PAUSE, pulse `step` → exactly one `tick`, `running` high for the remaining period, then PAUSE. `start`+`stop`+`step` together in RUN → PAUSE.
- **Asynchronous reset mid-run:** drop `reset` mid-period in RUN at `cnt`=7 → outputs 0 before the next edge. After release, `start` → first `tick` 10 cycles later.
